// File: rtl/spk_out_arb.sv
// Spike-out arbiter: merges soma spike fires (queued) and config flits (1-entry hold)
// onto the single flit FIFO push port with bounded config starvation.
module spk_out_arb #(
    parameter int FW        = 59,
    parameter int FTW       = 3,
    parameter int SW        = 24,
    parameter int SQB       = 3,
    parameter int SPK_BURST = 4,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soma_spk_out_fire,
    input  logic [SW-1:0]     soma_spk_out_neuid,
    input  logic              config_spk_out_we,
    input  logic [FW-1:0]     config_spk_out_wdata,
    output logic              spk_out_config_full,
    output logic              spk_out_push,
    output logic [FW-1:0]     spk_out_push_data,
    input  logic              spk_out_fifo_full,
    output logic [CW-1:0]     spk_drop_cnt,
    output logic [SQB:0]      spk_q_level
);

    localparam int DEPTH = 1 << SQB;
    localparam int BW    = $clog2(SPK_BURST + 2);
    localparam logic [BW-1:0]  BURST_MAX = BW'(SPK_BURST);
    localparam logic [SQB:0]   Q_DEPTH   = (SQB + 1)'(DEPTH);

    logic [SW-1:0]  q_mem [DEPTH];
    logic [SQB-1:0] wr_ptr;
    logic [SQB-1:0] rd_ptr;
    logic [SQB:0]   level;
    logic           cfg_valid;
    logic [FW-1:0]  cfg_flit;
    logic [BW-1:0]  bcnt;
    logic [CW-1:0]  drop_cnt;

    logic soma_pend;
    logic q_full;
    logic push;
    logic grant_soma;
    logic grant_cfg;
    logic accept;
    logic drop;

    assign soma_pend  = (level != '0);
    assign q_full     = (level == Q_DEPTH);
    assign push       = !spk_out_fifo_full && (cfg_valid || soma_pend);
    // Soma wins unless a waiting config flit has already sat through a full burst.
    assign grant_soma = push && soma_pend && (!cfg_valid || (bcnt < BURST_MAX));
    assign grant_cfg  = push && cfg_valid && !grant_soma;
    // A fire into a full queue still fits if the head leaves on the same edge.
    assign accept     = soma_spk_out_fire && (!q_full || grant_soma);
    assign drop       = soma_spk_out_fire && q_full && !grant_soma;

    always_ff @(posedge clk) begin
        if (accept) begin
            q_mem[wr_ptr] <= soma_spk_out_neuid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cfg_valid <= 1'b0;
            cfg_flit  <= '0;
            bcnt      <= '0;
            drop_cnt  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_soma) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, grant_soma})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (grant_cfg) begin
                cfg_valid <= 1'b0;
            end else if (config_spk_out_we && !cfg_valid) begin
                cfg_valid <= 1'b1;
                cfg_flit  <= config_spk_out_wdata;
            end

            if (grant_cfg) begin
                bcnt <= '0;
            end else if (grant_soma && cfg_valid) begin
                bcnt <= bcnt + 1'b1;
            end

            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        spk_out_push_data = '0;
        if (grant_soma) begin
            spk_out_push_data = {{FTW{1'b0}}, {(FW - SW - FTW){1'b0}}, q_mem[rd_ptr]};
        end else if (grant_cfg) begin
            spk_out_push_data = cfg_flit;
        end
    end

    assign spk_out_push        = push;
    assign spk_out_config_full = cfg_valid;
    assign spk_drop_cnt        = drop_cnt;
    assign spk_q_level         = level;

endmodule

// File: tb/tb_spk_out_arb.sv
// Bench for spk_out_arb: queue/arbitration model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_spk_out_arb;

    localparam int SPK_BURST = 4;
    localparam int DEPTH     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire = 1'b0;
    logic [23:0] neuid = '0;
    logic        we = 1'b0;
    logic [58:0] wdata = '0;
    logic        cfg_full;
    logic        push;
    logic [58:0] push_data;
    logic        fifo_full = 1'b0;
    logic [7:0]  drop_cnt;
    logic [3:0]  q_level;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [23:0] mq[$];
    bit          mcfg_v = 0;
    logic [58:0] mcfg = '0;
    int          mstreak = 0;
    int          mdrop = 0;
    logic [58:0] push_log[$];

    logic        e_push;
    logic [58:0] e_data;

    spk_out_arb dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .soma_spk_out_fire    (fire),
        .soma_spk_out_neuid   (neuid),
        .config_spk_out_we    (we),
        .config_spk_out_wdata (wdata),
        .spk_out_config_full  (cfg_full),
        .spk_out_push         (push),
        .spk_out_push_data    (push_data),
        .spk_out_fifo_full    (fifo_full),
        .spk_drop_cnt         (drop_cnt),
        .spk_q_level          (q_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        mq.delete();
        mcfg_v  = 0;
        mstreak = 0;
        mdrop   = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit p, gs, gc, cfg_pre;
            int sz_pre;
            cfg_pre = mcfg_v;
            sz_pre  = mq.size();
            p  = !fifo_full && (cfg_pre || sz_pre != 0);
            gs = p && sz_pre != 0 && (!cfg_pre || mstreak < SPK_BURST);
            gc = p && cfg_pre && !gs;
            if (gs) begin
                void'(mq.pop_front());
                if (cfg_pre) mstreak++;
            end
            if (gc) begin
                mcfg_v  = 0;
                mstreak = 0;
            end
            if (fire) begin
                if (sz_pre < DEPTH || gs) mq.push_back(neuid);
                else if (mdrop < 255) mdrop++;
            end
            if (we && !cfg_pre) begin
                mcfg_v = 1;
                mcfg   = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_push", 64'(push), 64'd0);
            chk("rst_data", 64'(push_data), 64'd0);
            chk("rst_cfg_full", 64'(cfg_full), 64'd0);
            chk("rst_drop", 64'(drop_cnt), 64'd0);
            chk("rst_level", 64'(q_level), 64'd0);
        end else begin
            e_push = !fifo_full && (mcfg_v || mq.size() != 0);
            e_data = '0;
            if (e_push) begin
                if (mq.size() != 0 && (!mcfg_v || mstreak < SPK_BURST)) e_data = {35'b0, mq[0]};
                else e_data = mcfg;
            end
            chk("push", 64'(push), 64'(e_push));
            chk("push_data", 64'(push_data), 64'(e_data));
            chk("config_full", 64'(cfg_full), 64'(mcfg_v));
            chk("q_level", 64'(q_level), 64'(mq.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
            if (push) push_log.push_back(push_data);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_fire(input logic [23:0] id);
        fire  = 1'b1;
        neuid = id;
        tick();
        fire  = 1'b0;
    endtask

    task automatic do_we(input logic [58:0] flit);
        we    = 1'b1;
        wdata = flit;
        tick();
        we    = 1'b0;
    endtask

    localparam logic [58:0] CFG_T4 = 59'h6_0000_0000_00AB;
    localparam logic [58:0] CFG_A  = 59'h7_1234_5678_9ABC;
    localparam logic [58:0] CFG_B  = 59'h5_0000_DEAD_BEEF;

    initial begin
        // T1: reset, then reset asserted mid-traffic
        tick(3);
        rst_n = 1'b1;
        fifo_full = 1'b1;
        for (int i = 1; i <= 10; i++) do_fire(24'(i));
        do_we(CFG_A);
        chk("t1_drop_pre", 64'(drop_cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_push_now", 64'(push), 64'd0);
        chk("t1_cfg_full_now", 64'(cfg_full), 64'd0);
        chk("t1_drop_now", 64'(drop_cnt), 64'd0);
        chk("t1_level_now", 64'(q_level), 64'd0);
        fifo_full = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t1_idle_push", 64'(push), 64'd0);

        // T2: single fire, push one cycle later
        do_fire(24'h0A0B0C);
        chk("t2_push", 64'(push), 64'd1);
        chk("t2_data", 64'(push_data), 64'h0A0B0C);
        tick();
        chk("t2_level", 64'(q_level), 64'd0);

        // T3: overflow while FIFO full
        fifo_full = 1'b1;
        for (int i = 1; i <= 20; i++) do_fire(24'(i));
        chk("t3_level", 64'(q_level), 64'd8);
        chk("t3_drop", 64'(drop_cnt), 64'd12);
        push_log.delete();
        fifo_full = 1'b0;
        tick(8);
        chk("t3_npush", 64'(push_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < push_log.size(); i++)
            chk("t3_order", 64'(push_log[i]), 64'(i + 1));

        // T4: fairness, config waits for a burst of SPK_BURST spikes
        fifo_full = 1'b1;
        for (int i = 1; i <= 8; i++) do_fire(24'(i));
        do_we(CFG_T4);
        push_log.delete();
        fifo_full = 1'b0;
        tick(9);
        chk("t4_npush", 64'(push_log.size()), 64'd9);
        if (push_log.size() == 9) begin
            chk("t4_p0", 64'(push_log[0]), 64'd1);
            chk("t4_p3", 64'(push_log[3]), 64'd4);
            chk("t4_cfg", 64'(push_log[4]), 64'(CFG_T4));
            chk("t4_p5", 64'(push_log[5]), 64'd5);
            chk("t4_p8", 64'(push_log[8]), 64'd8);
        end

        // T5: second config write while holding register occupied is lost
        fifo_full = 1'b1;
        do_we(CFG_A);
        do_we(CFG_B);
        tick();
        chk("t5_cfg_full", 64'(cfg_full), 64'd1);
        push_log.delete();
        fifo_full = 1'b0;
        tick();
        chk("t5_cfg_full_after", 64'(cfg_full), 64'd0);
        tick();
        chk("t5_npush", 64'(push_log.size()), 64'd1);
        if (push_log.size() == 1) chk("t5_flit", 64'(push_log[0]), 64'(CFG_A));

        // T6: fire into a full queue on the cycle the head is pushed
        fifo_full = 1'b1;
        for (int i = 101; i <= 108; i++) do_fire(24'(i));
        push_log.delete();
        fifo_full = 1'b0;
        do_fire(24'd9);
        chk("t6_level", 64'(q_level), 64'd8);
        chk("t6_drop", 64'(drop_cnt), 64'd12);
        tick(8);
        chk("t6_npush", 64'(push_log.size()), 64'd9);
        if (push_log.size() == 9) begin
            chk("t6_first", 64'(push_log[0]), 64'd101);
            chk("t6_last", 64'(push_log[8]), 64'd9);
        end

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            fire      = 1'($urandom_range(0, 1));
            neuid     = 24'($urandom());
            we        = ($urandom_range(0, 3) == 0);
            wdata     = 59'({$urandom(), $urandom()});
            fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        fire = 1'b0;
        we = 1'b0;
        fifo_full = 1'b0;
        tick(20);
        chk("drain_level", 64'(q_level), 64'd0);

        // drop counter saturation
        fifo_full = 1'b1;
        for (int i = 0; i < 270; i++) do_fire(24'(i));
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        fifo_full = 1'b0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
